wavelet_engine_seq: RTL and testbench



---
 rtl/wavelet_engine_seq_if.sv | 47 ++++
 rtl/wavelet_engine_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_wavelet_engine_seq.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/wavelet_engine_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : wavelet_engine_seq_if
//  Description : Bundles the sample, coefficient-write, output-select and
//                status signals of wavelet_engine_seq into one interface.
//                master = the driving side (sample source / host),
//                slave  = the wavelet engine.
//  Signals     : i_value                   sample value
//                i_data_clk                sample strobe
//                i_coef_we/_chan/_tap/_data coefficient write port
//                i_select_output_channel   output channel select
//                o_multiplexed_wavelet_out selected channel result
//                o_active/o_busy/o_frame_done/o_overrun  status
//  Revision    : 1.0  initial release
// ============================================================================
interface wavelet_engine_seq_if #(
    parameter int BITS_PER_ELEM  = 8,
    parameter int SUM_TRUNCATION = 8
);
    logic signed [BITS_PER_ELEM-1:0]  i_value;
    logic                             i_data_clk;
    logic                             i_coef_we;
    logic        [7:0]                i_coef_chan;
    logic        [7:0]                i_coef_tap;
    logic signed [BITS_PER_ELEM-1:0]  i_coef_data;
    logic        [7:0]                i_select_output_channel;
    logic        [SUM_TRUNCATION-1:0] o_multiplexed_wavelet_out;
    logic                             o_active;
    logic                             o_busy;
    logic                             o_frame_done;
    logic                             o_overrun;

    modport master (
        output i_value, i_data_clk, i_coef_we, i_coef_chan, i_coef_tap,
               i_coef_data, i_select_output_channel,
        input  o_multiplexed_wavelet_out, o_active, o_busy, o_frame_done,
               o_overrun
    );

    modport slave (
        input  i_value, i_data_clk, i_coef_we, i_coef_chan, i_coef_tap,
               i_coef_data, i_select_output_channel,
        output o_multiplexed_wavelet_out, o_active, o_busy, o_frame_done,
               o_overrun
    );
endinterface
`default_nettype wire

// File: rtl/wavelet_engine_seq.sv
`default_nettype none
// ============================================================================
//  Module      : wavelet_engine_seq
//  Description : Time-multiplexed FIR wavelet engine. A single signed MAC is
//                swept over NUM_CHANNELS channels that share one sample delay
//                line. Each sample strobe starts a frame of sum(CH_LEN) MAC
//                cycles; every channel result is shifted by its CH_SHIFT and
//                held until the next frame rewrites it.
//  Ports       : clk                 system clock
//                rst                 synchronous active-high reset
//                wv (slave modport)  sample input, coefficient write port,
//                                    output select, result and status
//  Options     : WAVELET_SATURATE_EN  clamp shifted results to the signed
//                                     SUM_TRUNCATION range instead of
//                                     wrapping
//  Revision    : 1.0  initial release
// ============================================================================
module wavelet_engine_seq #(
    parameter int                          BITS_PER_ELEM  = 8,
    parameter int                          NUM_CHANNELS   = 8,
    parameter int                          MAX_TAPS       = 141,
    parameter logic [8*NUM_CHANNELS-1:0]   CH_LEN         = 64'h8D512F1B0F090503,
    parameter logic [8*NUM_CHANNELS-1:0]   CH_SHIFT       = 64'h0D0C0B0A0A090808,
    parameter int                          ACC_BITS       = 24,
    parameter int                          SUM_TRUNCATION = 8
) (
    input  wire                  clk,
    input  wire                  rst,
    wavelet_engine_seq_if.slave  wv
);

    localparam int c_CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int c_TAP_W = (MAX_TAPS > 1) ? $clog2(MAX_TAPS) : 1;
    localparam int c_PROD_W = 2 * BITS_PER_ELEM;

    localparam logic [8:0]        c_NUM_CH   = 9'(NUM_CHANNELS);
    localparam logic [8:0]        c_NUM_TAPS = 9'(MAX_TAPS);
    localparam logic [c_CH_W-1:0] c_LAST_CH  = c_CH_W'(NUM_CHANNELS - 1);

    localparam logic signed [ACC_BITS-1:0] c_SAT_MAX =
        ACC_BITS'((1 << (SUM_TRUNCATION - 1)) - 1);
    localparam logic signed [ACC_BITS-1:0] c_SAT_MIN =
        ACC_BITS'(-(1 << (SUM_TRUNCATION - 1)));

`ifdef WAVELET_SATURATE_EN
    localparam logic c_SAT_EN = 1'b1;
`else
    localparam logic c_SAT_EN = 1'b0;
`endif

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        [1:0]                r_state;
    logic                             r_dc;
    logic                             r_active;
    logic                             r_busy;
    logic                             r_frame_done;
    logic                             r_overrun;
    logic        [c_CH_W-1:0]         r_chan;
    logic        [c_TAP_W-1:0]        r_tap;
    logic signed [ACC_BITS-1:0]       r_acc;
    logic        [SUM_TRUNCATION-1:0] r_out;

    logic signed [BITS_PER_ELEM-1:0]  r_taps   [MAX_TAPS];
    logic signed [BITS_PER_ELEM-1:0]  r_coef   [NUM_CHANNELS][MAX_TAPS];
    logic        [SUM_TRUNCATION-1:0] r_result [NUM_CHANNELS];

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic                             w_edge;
    logic        [7:0]                w_len;
    logic        [7:0]                w_shift;
    logic                             w_last_tap;
    logic                             w_last_ch;
    logic signed [BITS_PER_ELEM-1:0]  w_tap_val;
    logic signed [BITS_PER_ELEM-1:0]  w_coef_val;
    logic signed [c_PROD_W-1:0]       w_prod;
    logic signed [ACC_BITS-1:0]       w_prod_ext;
    logic signed [ACC_BITS-1:0]       w_sum;
    logic signed [ACC_BITS-1:0]       w_shifted;
    logic        [SUM_TRUNCATION-1:0] w_res_wrap;
    logic        [SUM_TRUNCATION-1:0] w_res_sat;
    logic        [SUM_TRUNCATION-1:0] w_res;
    logic                             w_coef_ok;
    logic                             w_sel_ok;

    // The strobe is used directly; it is expected to be clk-synchronous.
    assign w_edge     = wv.i_data_clk & ~r_dc;

    assign w_len      = CH_LEN[{r_chan, 3'b000} +: 8];
    assign w_shift    = CH_SHIFT[{r_chan, 3'b000} +: 8];
    assign w_last_tap = (8'(r_tap) == (w_len - 8'd1));
    assign w_last_ch  = (r_chan == c_LAST_CH);

    assign w_tap_val  = r_taps[r_tap];
    assign w_coef_val = r_coef[r_chan][r_tap];
    assign w_prod     = $signed({{BITS_PER_ELEM{w_tap_val[BITS_PER_ELEM-1]}}, w_tap_val})
                      * $signed({{BITS_PER_ELEM{w_coef_val[BITS_PER_ELEM-1]}}, w_coef_val});
    assign w_prod_ext = {{(ACC_BITS - c_PROD_W){w_prod[c_PROD_W-1]}}, w_prod};
    assign w_sum      = r_acc + w_prod_ext;
    assign w_shifted  = w_sum >>> w_shift;
    assign w_res_wrap = w_shifted[SUM_TRUNCATION-1:0];

    always_comb begin
        w_res_sat = w_shifted[SUM_TRUNCATION-1:0];
        if (w_shifted > c_SAT_MAX) begin
            w_res_sat = c_SAT_MAX[SUM_TRUNCATION-1:0];
        end else if (w_shifted < c_SAT_MIN) begin
            w_res_sat = c_SAT_MIN[SUM_TRUNCATION-1:0];
        end
    end

    assign w_res     = c_SAT_EN ? w_res_sat : w_res_wrap;

    assign w_coef_ok = wv.i_coef_we
                     && ({1'b0, wv.i_coef_chan} < c_NUM_CH)
                     && ({1'b0, wv.i_coef_tap}  < c_NUM_TAPS);
    assign w_sel_ok  = ({1'b0, wv.i_select_output_channel} < c_NUM_CH);

    // ------------------------------------------------------------------
    // Control, storage and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_dc         <= 1'b0;
            r_active     <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            r_chan       <= '0;
            r_tap        <= '0;
            r_acc        <= '0;
            r_out        <= '0;
            for (int k = 0; k < MAX_TAPS; k++) begin
                r_taps[k] <= '0;
            end
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_result[c] <= '0;
                for (int k = 0; k < MAX_TAPS; k++) begin
                    r_coef[c][k] <= '0;
                end
            end
        end else begin
            r_dc         <= wv.i_data_clk;
            r_active     <= 1'b1;
            r_frame_done <= 1'b0;

            // The MAC reads r_coef combinationally this cycle, so a write to
            // the same entry only takes effect from the next cycle.
            if (w_coef_ok) begin
                r_coef[wv.i_coef_chan[c_CH_W-1:0]][wv.i_coef_tap[c_TAP_W-1:0]] <= wv.i_coef_data;
            end

            r_out <= w_sel_ok ? r_result[wv.i_select_output_channel[c_CH_W-1:0]] : '0;

            // Any strobe outside IDLE is dropped and flagged.
            if (w_edge && (r_state != c_ST_IDLE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_edge) begin
                        r_taps[0] <= wv.i_value;
                        for (int k = 1; k < MAX_TAPS; k++) begin
                            r_taps[k] <= r_taps[k-1];
                        end
                        r_state <= c_ST_CALC;
                        r_busy  <= 1'b1;
                        r_chan  <= '0;
                        r_tap   <= '0;
                        r_acc   <= '0;
                    end
                end

                c_ST_CALC: begin
                    if (w_last_tap) begin
                        // Final product of this channel is folded in here
                        // rather than via r_acc, so no extra cycle per channel.
                        r_result[r_chan] <= w_res;
                        r_acc            <= '0;
                        r_tap            <= '0;
                        if (w_last_ch) begin
                            r_chan       <= '0;
                            r_state      <= c_ST_DONE;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_chan <= r_chan + c_CH_W'(1);
                        end
                    end else begin
                        r_acc <= w_sum;
                        r_tap <= r_tap + c_TAP_W'(1);
                    end
                end

                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign wv.o_multiplexed_wavelet_out = r_out;
    assign wv.o_active                  = r_active;
    assign wv.o_busy                    = r_busy;
    assign wv.o_frame_done              = r_frame_done;
    assign wv.o_overrun                 = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_wavelet_engine_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wavelet_engine_seq
//  Description : Self-checking bench for wavelet_engine_seq. A vector table
//                of single-tap frames covers every channel's shift, followed
//                by hand-written sequences for output select, overrun,
//                multi-tap accumulation (wrap or saturation), mid-frame
//                reset and out-of-range coefficient writes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wavelet_engine_seq;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wavelet_engine_seq_if #(.BITS_PER_ELEM(8), .SUM_TRUNCATION(8)) wv ();

    wavelet_engine_seq dut (
        .clk (clk),
        .rst (rst),
        .wv  (wv)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] chan;
        logic [7:0] coef;
        logic [7:0] value;
        logic [7:0] expected;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input logic [7:0] ch, input logic [7:0] tap, input logic [7:0] data);
        wv.i_coef_we   = 1'b1;
        wv.i_coef_chan = ch;
        wv.i_coef_tap  = tap;
        wv.i_coef_data = data;
        tick();
        wv.i_coef_we   = 1'b0;
    endtask

    // Strobe one sample and wait for o_frame_done. cycles counts clocks
    // from the edge cycle; an optional second strobe is issued at extra_at.
    task automatic run_frame(input logic [7:0] value, input int extra_at,
                             input logic [7:0] extra_value, output int cycles);
        wv.i_value    = value;
        wv.i_data_clk = 1'b1;
        tick();
        wv.i_data_clk = 1'b0;
        cycles = 1;
        while (wv.o_frame_done !== 1'b1 && cycles < 1000) begin
            if (cycles == extra_at) begin
                wv.i_value    = extra_value;
                wv.i_data_clk = 1'b1;
            end else begin
                wv.i_data_clk = 1'b0;
            end
            tick();
            cycles++;
        end
        wv.i_data_clk = 1'b0;
    endtask

    task automatic frame_and_read(input string name, input logic [7:0] value,
                                  input logic [7:0] sel, input logic [7:0] exp);
        int cyc;
        run_frame(value, -1, 8'h00, cyc);
        check({name, "_frame_len"}, cyc, 329);
        wv.i_select_output_channel = sel;
        tick();
        check({name, "_out"}, wv.o_multiplexed_wavelet_out, exp);
    endtask

    initial begin
        int cyc;
        int cnt;
        logic seen_done;
        logic [7:0] sat_exp;

        // chan, coef, value, expected (single tap 0, other coefs zero)
        vecs[0] = '{8'd0, 8'h7F, 8'h40, 8'h1F};
        vecs[1] = '{8'd0, 8'h7F, 8'h80, 8'hC0};
        vecs[2] = '{8'd1, 8'h40, 8'h40, 8'h10};
        vecs[3] = '{8'd2, 8'h7F, 8'h7F, 8'h1F};
        vecs[4] = '{8'd3, 8'h80, 8'h80, 8'h10};
        vecs[5] = '{8'd4, 8'hCE, 8'h64, 8'hFB};
        vecs[6] = '{8'd5, 8'h80, 8'h7F, 8'hF8};
        vecs[7] = '{8'd6, 8'h7F, 8'h7F, 8'h03};
        vecs[8] = '{8'd7, 8'h7F, 8'h80, 8'hFE};

        rst                        = 1'b1;
        wv.i_value                 = '0;
        wv.i_data_clk              = 1'b0;
        wv.i_coef_we               = 1'b0;
        wv.i_coef_chan             = '0;
        wv.i_coef_tap              = '0;
        wv.i_coef_data             = '0;
        wv.i_select_output_channel = '0;

        // ---------------- reset state ----------------
        repeat (3) tick();
        check("rst_out",        wv.o_multiplexed_wavelet_out, 0);
        check("rst_active",     wv.o_active, 0);
        check("rst_busy",       wv.o_busy, 0);
        check("rst_frame_done", wv.o_frame_done, 0);
        check("rst_overrun",    wv.o_overrun, 0);
        rst = 1'b0;
        tick();
        check("active_after_release", wv.o_active, 1);
        check("busy_after_release",   wv.o_busy, 0);
        check("overrun_after_release", wv.o_overrun, 0);

        // ---------------- vector table ----------------
        for (int i = 0; i < 9; i++) begin
            write_coef(vecs[i].chan, 8'd0, vecs[i].coef);
            run_frame(vecs[i].value, -1, 8'h00, cyc);
            check($sformatf("vec%0d_frame_len", i), cyc, 329);
            check($sformatf("vec%0d_busy_in_done", i), wv.o_busy, 1);
            wv.i_select_output_channel = vecs[i].chan;
            tick();
            check($sformatf("vec%0d_done_pulse_width", i), wv.o_frame_done, 0);
            check($sformatf("vec%0d_busy_after", i), wv.o_busy, 0);
            check($sformatf("vec%0d_out", i), wv.o_multiplexed_wavelet_out, vecs[i].expected);
            write_coef(vecs[i].chan, 8'd0, 8'h00);
        end

        // ---------------- output select ----------------
        wv.i_select_output_channel = 8'd9;
        tick();
        check("sel_out_of_range", wv.o_multiplexed_wavelet_out, 0);
        wv.i_select_output_channel = 8'd7;
        tick();
        check("sel_back_to_ch7", wv.o_multiplexed_wavelet_out, 8'hFE);
        check("no_overrun_yet", wv.o_overrun, 0);

        // ---------------- overrun ----------------
        run_frame(8'h20, 10, 8'h60, cyc);
        check("overrun_frame_len", cyc, 329);
        check("overrun_set", wv.o_overrun, 1);
        tick();
        write_coef(8'd0, 8'd1, 8'h7F);
        wv.i_select_output_channel = 8'd0;
        // tap[1] must hold 0x20, not the dropped 0x60: 32*127>>>8 = 15
        frame_and_read("tap1_history", 8'h10, 8'd0, 8'h0F);
        check("overrun_sticky", wv.o_overrun, 1);

        // ---------------- multi-tap accumulation ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("overrun_cleared", wv.o_overrun, 0);
        write_coef(8'd0, 8'd0, 8'h7F);
        write_coef(8'd0, 8'd1, 8'h7F);
        write_coef(8'd0, 8'd2, 8'h7F);
        frame_and_read("acc_1", 8'h7F, 8'd0, 8'h3F);
        frame_and_read("acc_2", 8'h7F, 8'd0, 8'h7E);
`ifdef WAVELET_SATURATE_EN
        sat_exp = 8'h7F;
`else
        sat_exp = 8'hBD;
`endif
        frame_and_read("acc_3", 8'h7F, 8'd0, sat_exp);

        // ---------------- reset mid-CALC ----------------
        wv.i_value    = 8'h7F;
        wv.i_data_clk = 1'b1;
        tick();
        wv.i_data_clk = 1'b0;
        cnt = 1;
        while (cnt < 50) begin
            wv.i_data_clk = (cnt == 10);
            tick();
            cnt++;
        end
        wv.i_data_clk = 1'b0;
        check("midcalc_busy_before", wv.o_busy, 1);
        check("midcalc_overrun_before", wv.o_overrun, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midcalc_busy",       wv.o_busy, 0);
        check("midcalc_overrun",    wv.o_overrun, 0);
        check("midcalc_frame_done", wv.o_frame_done, 0);
        check("midcalc_out",        wv.o_multiplexed_wavelet_out, 0);
        check("midcalc_active",     wv.o_active, 0);
        tick();
        check("midcalc_active_back", wv.o_active, 1);
        for (int c = 0; c < 8; c++) begin
            wv.i_select_output_channel = 8'(c);
            tick();
            check($sformatf("midcalc_result_ch%0d", c), wv.o_multiplexed_wavelet_out, 0);
        end
        seen_done = 1'b0;
        repeat (340) begin
            if (wv.o_frame_done === 1'b1 || wv.o_busy === 1'b1) seen_done = 1'b1;
            tick();
        end
        check("midcalc_no_resume", seen_done, 0);

        // ---------------- out-of-range coefficient writes ----------------
        write_coef(8'd8,   8'd0,   8'h7F);
        write_coef(8'd255, 8'd0,   8'h7F);
        write_coef(8'd0,   8'd141, 8'h7F);
        write_coef(8'd7,   8'd141, 8'h7F);
        run_frame(8'h7F, -1, 8'h00, cyc);
        check("badwr_frame_len", cyc, 329);
        tick();
        for (int c = 0; c < 8; c++) begin
            wv.i_select_output_channel = 8'(c);
            tick();
            check($sformatf("badwr_result_ch%0d", c), wv.o_multiplexed_wavelet_out, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
